// File: rtl/waterlight_sequencer_if.sv
// rtl/waterlight_sequencer_if.sv - configuration/LED bundle between register slave, sequencer and board
//
// Purpose: groups the pattern configuration inputs and the LED/status outputs
// of the water-light sequencer.
// Signals:
//   mode   pattern select from the mode config register
//   speed  step period in HCLK cycles from the speed config register
//   led    LED drive, 1 = lit
//   step   one-cycle pulse in the cycle led advanced
//   state  pattern FSM state code for status readback
// Modports:
//   master  side that owns the configuration and observes the LEDs
//   slave   the sequencer itself
interface waterlight_sequencer_if #(
    parameter int LED_W   = 8,
    parameter int SPEED_W = 32
);
    logic [7:0]         mode;
    logic [SPEED_W-1:0] speed;
    logic [LED_W-1:0]   led;
    logic               step;
    logic [2:0]         state;

    modport master (
        output mode,
        output speed,
        input  led,
        input  step,
        input  state
    );

    modport slave (
        input  mode,
        input  speed,
        output led,
        output step,
        output state
    );
endinterface

// File: rtl/waterlight_sequencer.sv
// rtl/waterlight_sequencer.sv - prescaled LED pattern sequencer (rotate/bounce/blink)
//
// Purpose: a programmable prescaler produces one tick every max(speed, MIN_SPEED)
// cycles; each tick advances the LED pattern selected by mode. A change of mode
// restarts the pattern from its start value; a change of speed never does.
// Ports:
//   HCLK    system clock
//   HRESET  synchronous, active-high reset
//   bus     slave modport: mode/speed in, led/step/state out (all outputs registered)
module waterlight_sequencer #(
    parameter int LED_W     = 8,
    parameter int SPEED_W   = 32,
    parameter int MIN_SPEED = 2
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    waterlight_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_LEFT   = 3'd1,
        ST_RIGHT  = 3'd2,
        ST_BOUNCE = 3'd3,
        ST_BLINK  = 3'd4
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [SPEED_W-1:0] MIN_SPEED_V = SPEED_W'(MIN_SPEED);
    localparam logic [LED_W-1:0]   PAT_LSB     = LED_W'(1);
    localparam logic [LED_W-1:0]   PAT_MSB     = {1'b1, {(LED_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               step_q, step_d;
    logic [SPEED_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic [7:0]         mode_q, mode_d;

    logic [SPEED_W-1:0] eff_m1;
    logic               tick;
    logic               restart;
    logic               bounce_dir;

    function automatic state_t decode_mode(input logic [7:0] m);
        case (m)
            8'h01:   decode_mode = ST_LEFT;
            8'h02:   decode_mode = ST_RIGHT;
            8'h03:   decode_mode = ST_BOUNCE;
            8'h04:   decode_mode = ST_BLINK;
            default: decode_mode = ST_OFF;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] start_pattern(input state_t s);
        case (s)
            ST_LEFT:   start_pattern = PAT_LSB;
            ST_RIGHT:  start_pattern = PAT_MSB;
            ST_BOUNCE: start_pattern = PAT_LSB;
            ST_BLINK:  start_pattern = '1;
            default:   start_pattern = '0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        step_d     = 1'b0;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = bus.mode;
        bounce_dir = dir_q;

        // Clamp the period so a tiny speed cannot produce a step every cycle.
        eff_m1  = ((bus.speed < MIN_SPEED_V) ? MIN_SPEED_V : bus.speed) - 1'b1;
        // >= rather than == so lowering speed mid-count ticks at once instead
        // of running cnt all the way around the counter.
        tick    = (cnt_q >= eff_m1);
        restart = (bus.mode != mode_q);

        if (restart) begin
            // A restart overrides a coincident tick: no shift, no step.
            state_d = decode_mode(bus.mode);
            led_d   = start_pattern(decode_mode(bus.mode));
            cnt_d   = '0;
            dir_d   = DIR_LEFT;
        end else if (state_q == ST_OFF) begin
            cnt_d = '0;
            led_d = '0;
        end else if (tick) begin
            cnt_d  = '0;
            step_d = 1'b1;
            case (state_q)
                ST_LEFT:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                ST_RIGHT: led_d = {led_q[0], led_q[LED_W-1:1]};
                ST_BOUNCE: begin
                    // Turn around at either end before shifting, so the end
                    // bit is shown for exactly one step.
                    if (led_q[LED_W-1]) begin
                        bounce_dir = DIR_RIGHT;
                    end else if (led_q[0]) begin
                        bounce_dir = DIR_LEFT;
                    end
                    dir_d = bounce_dir;
                    led_d = (bounce_dir == DIR_LEFT) ? (led_q << 1) : (led_q >> 1);
                end
                ST_BLINK: led_d = ~led_q;
                default:  led_d = '0;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_OFF;
            led_q   <= '0;
            step_q  <= 1'b0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            mode_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.step  = step_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_waterlight_sequencer.sv
// tb/tb_waterlight_sequencer.sv - self-checking bench for waterlight_sequencer
module tb_waterlight_sequencer;

    logic HCLK;
    logic HRESET;

    waterlight_sequencer_if #(.LED_W(8), .SPEED_W(32)) bus ();

    waterlight_sequencer #(.LED_W(8), .SPEED_W(32), .MIN_SPEED(2)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int vectors     = 0;
    int miscompares = 0;
    int steps_seen  = 0;

    // Reference model: mode seen, state code, steps since restart, cycles since last step.
    int     m_mode  = 0;
    int     m_state = 0;
    int     m_k     = 0;
    longint m_cnt   = 0;
    logic   m_step  = 1'b0;

    function automatic int decode(input int m);
        return (m >= 1 && m <= 4) ? m : 0;
    endfunction

    // Pattern after k steps, derived directly from the pattern rules.
    function automatic logic [7:0] pattern(input int st, input int k);
        int pos;
        case (st)
            1: return 8'(1 << (k % 8));
            2: return 8'(128 >> (k % 8));
            3: begin
                pos = k % 14;
                return 8'(1 << ((pos <= 7) ? pos : 14 - pos));
            end
            4: return ((k % 2) == 0) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic longint eff_period(input logic [31:0] s);
        return (s < 32'd2) ? 64'd2 : longint'(s);
    endfunction

    task automatic model_update();
        if (HRESET) begin
            m_mode = 0; m_state = 0; m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (int'(bus.mode) != m_mode) begin
            m_mode = int'(bus.mode); m_state = decode(m_mode);
            m_k = 0; m_cnt = 0; m_step = 1'b0;
        end else if (m_state == 0) begin
            m_cnt = 0; m_step = 1'b0;
        end else if (m_cnt + 1 >= eff_period(bus.speed)) begin
            m_cnt = 0; m_k++; m_step = 1'b1;
        end else begin
            m_cnt++; m_step = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_update();
        #1;
        if (bus.step === 1'b1) steps_seen++;
        check("led",   32'(bus.led),   32'(pattern(m_state, m_k)));
        check("step",  32'(bus.step),  32'(m_step));
        check("state", 32'(bus.state), 32'(m_state));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        HRESET    = 1'b1;
        bus.mode  = 8'h01;
        bus.speed = 32'd4;

        // Reset held two cycles with a live mode.
        ticks(2);
        check("rst_led",   32'(bus.led),   32'h00);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_step",  32'(bus.step),  32'd0);
        HRESET = 1'b0;
        tick();
        check("rel_led",   32'(bus.led),   32'h01);
        check("rel_state", 32'(bus.state), 32'd1);

        // LEFT, speed 4: 8 steps in 32 cycles, back to 0x01.
        steps_seen = 0;
        ticks(32);
        check("left_steps", 32'(steps_seen), 32'd8);
        check("left_wrap",  32'(bus.led),    32'h01);

        // BOUNCE, speed 2: 14-step period.
        bus.mode = 8'h03; bus.speed = 32'd2;
        tick();
        check("bounce_start", 32'(bus.led), 32'h01);
        steps_seen = 0;
        ticks(28);
        check("bounce_steps", 32'(steps_seen), 32'd14);
        check("bounce_wrap",  32'(bus.led),    32'h01);

        // RIGHT with clamped speeds 0 and 1.
        bus.mode = 8'h02; bus.speed = 32'd0;
        tick();
        check("right_start", 32'(bus.led), 32'h80);
        steps_seen = 0;
        ticks(16);
        bus.speed = 32'd1;
        ticks(16);
        check("clamp_steps", 32'(steps_seen), 32'd16);
        check("right_wrap",  32'(bus.led),    32'h80);

        // Mode change coinciding with a tick: restart wins.
        bus.mode = 8'h01; bus.speed = 32'd3;
        tick();
        for (int i = 0; i < 10 && m_cnt != 2; i++) tick();
        check("coll_armed", 32'(m_cnt), 32'd2);
        bus.mode = 8'h04;
        tick();
        check("coll_led",  32'(bus.led),  32'hFF);
        check("coll_step", 32'(bus.step), 32'd0);
        ticks(3);
        check("blink_off", 32'(bus.led), 32'h00);
        ticks(3);
        check("blink_on",  32'(bus.led), 32'hFF);

        // Illegal mode behaves as OFF.
        bus.mode = 8'h7F;
        steps_seen = 0;
        ticks(100);
        check("off_steps", 32'(steps_seen), 32'd0);
        check("off_led",   32'(bus.led),    32'h00);

        // Speed drop mid-count steps on the next cycle.
        bus.mode = 8'h01; bus.speed = 32'd1000;
        tick();
        ticks(10);
        bus.speed = 32'd2;
        tick();
        check("drop_step", 32'(bus.step), 32'd1);

        // Randomized mode/speed/reset traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 6))
                    0: bus.mode = 8'h00;
                    1: bus.mode = 8'h01;
                    2: bus.mode = 8'h02;
                    3: bus.mode = 8'h03;
                    4: bus.mode = 8'h04;
                    5: bus.mode = 8'h05;
                    default: bus.mode = 8'hC3;
                endcase
            end
            if ($urandom_range(0, 7) == 0) bus.speed = 32'($urandom_range(0, 6));
            HRESET = ($urandom_range(0, 99) == 0);
            tick();
        end
        HRESET = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
